// File: rtl/mult_result_fifo_taint.sv
// Result FIFO behind the taint-tracked multiplier: edge-captures each product into a small FIFO with shadow taint.
// Optional drop counter outputs enabled by defining MULT_RESFIFO_OVFCNT_EN.
module mult_result_fifo_taint #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 productDone,
    input  logic                 productDone_t,
    input  logic [2*WIDTH-1:0]   product,
    input  logic [2*WIDTH-1:0]   product_t,
    input  logic                 out_ready,
    input  logic                 out_ready_t,
    output logic                 out_valid,
    output logic                 out_valid_t,
    output logic [2*WIDTH-1:0]   out_data,
    output logic [2*WIDTH-1:0]   out_data_t,
    output logic                 full,
    output logic                 full_t,
    output logic                 overflow,
    output logic                 overflow_t
`ifdef MULT_RESFIFO_OVFCNT_EN
    ,
    output logic [7:0]           drop_count,
    output logic [0:0]           drop_count_t
`endif
);

    localparam int PW = 2 * WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic              done_q_r;
    logic              done_q_t_r;
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_next_s;
    logic [PW-1:0]     mem_r   [DEPTH];
    logic [PW-1:0]     mem_t_r [DEPTH];
    logic              out_valid_r;
    logic              full_r;
    logic              ptr_t_r;
    logic              overflow_r;
    logic              overflow_t_r;

    logic              cap_s;
    logic              cap_t_s;
    logic              pop_s;
    logic              push_s;
    logic              ovf_set_s;
    logic              ptr_t_set_s;
    logic              ovf_t_set_s;

    // Capture/pop decisions and their taint for the current cycle.
    always_comb begin
        cap_s        = productDone & ~done_q_r;
        cap_t_s      = productDone_t | done_q_t_r;
        pop_s        = out_valid_r & out_ready;
        push_s       = cap_s & (~full_r | pop_s);
        ovf_set_s    = cap_s & full_r & ~pop_s;
        ptr_t_set_s  = (cap_s & cap_t_s) | (cap_t_s & full_r) | (out_valid_r & out_ready_t);
        ovf_t_set_s  = ovf_set_s & (cap_t_s | ptr_t_r);
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Edge detector, pointers, occupancy flags and sticky status.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q_r     <= 1'b0;
            done_q_t_r   <= 1'b0;
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            count_r      <= {CW{1'b0}};
            out_valid_r  <= 1'b0;
            full_r       <= 1'b0;
            ptr_t_r      <= 1'b0;
            overflow_r   <= 1'b0;
            overflow_t_r <= 1'b0;
        end else begin
            done_q_r     <= productDone;
            done_q_t_r   <= productDone_t;
            count_r      <= count_next_s;
            out_valid_r  <= (count_next_s != {CW{1'b0}});
            full_r       <= (count_next_s == DEPTH_C);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            ptr_t_r      <= ptr_t_r | ptr_t_set_s;
            overflow_r   <= overflow_r | ovf_set_s;
            overflow_t_r <= overflow_t_r | ovf_t_set_s;
        end
    end

    // Entry storage; cleared on reset so the empty head reads as zero with no taint.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i]   <= {PW{1'b0}};
                mem_t_r[i] <= {PW{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r]   <= product;
            mem_t_r[wr_ptr_r] <= product_t | {PW{cap_t_s}};
        end else begin
            mem_r[wr_ptr_r]   <= mem_r[wr_ptr_r];
            mem_t_r[wr_ptr_r] <= mem_t_r[wr_ptr_r];
        end
    end

`ifdef MULT_RESFIFO_OVFCNT_EN
    logic [7:0] drop_count_r;
    logic       drop_count_t_r;

    // Saturating count of dropped captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count_r   <= 8'd0;
            drop_count_t_r <= 1'b0;
        end else begin
            if (ovf_set_s && (drop_count_r != 8'hFF)) begin
                drop_count_r <= drop_count_r + 8'd1;
            end else begin
                drop_count_r <= drop_count_r;
            end
            drop_count_t_r <= drop_count_t_r | ovf_t_set_s;
        end
    end

    assign drop_count   = drop_count_r;
    assign drop_count_t = drop_count_t_r;
`endif

    assign out_valid   = out_valid_r;
    assign out_valid_t = ptr_t_r;
    assign full        = full_r;
    assign full_t      = ptr_t_r;
    assign overflow    = overflow_r;
    assign overflow_t  = overflow_t_r;
    assign out_data    = mem_r[rd_ptr_r];
    assign out_data_t  = mem_t_r[rd_ptr_r] | {PW{ptr_t_r}};

endmodule

// File: doc/mult_result_fifo_taint.md
Name: mult_result_fifo_taint

Overview:
- Downstream consumer of the taint-tracked sequential multiplier.
- Detects each completed product (rising edge of productDone), captures product plus its per-bit taint into a small FIFO, and presents results to a valid/ready consumer.
- Every control and data signal carries a shadow _t taint signal, following the same taint-propagation discipline as the multiplier, so information flow is traceable end to end.

Parameters:
- WIDTH, 8, multiplier operand width; stored product is 2*WIDTH bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- productDone  input  1  multiplier completion flag (level, may stay high several cycles).
- productDone_t  input  1  taint of productDone.
- product  input  2*WIDTH  multiplier result.
- product_t  input  2*WIDTH  per-bit taint of product.
- out_ready  input  1  consumer ready.
- out_ready_t  input  1  taint of out_ready.
- out_valid  output  1  head entry available.
- out_valid_t  output  1  taint of out_valid.
- out_data  output  2*WIDTH  head entry product.
- out_data_t  output  2*WIDTH  taint of out_data.
- full  output  1  count == DEPTH.
- full_t  output  1  taint of full.
- overflow  output  1  sticky: a capture was dropped.
- overflow_t  output  1  taint of overflow.

Behaviour:
- Single clock clk; reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset: pointers, count, done_q, and all taint registers go to 0. Outputs after reset: out_valid=0, full=0, overflow=0, out_data=0, and every _t output = 0. Entry storage need not be cleared.
- Edge detect:
  - done_q is a register of productDone.
  - cap = productDone & ~done_q.
  - cap_t = productDone_t | done_q_t.
  - A level held high for N cycles produces exactly one capture.
- Push: on cap with count < DEPTH, or with count == DEPTH and a pop in the same cycle:
  - Write product to mem[wr_ptr].
  - mem_t[wr_ptr] = product_t | {2*WIDTH{cap_t}}.
  - wr_ptr increments and wraps modulo DEPTH.
- Pop: pop = out_valid & out_ready; rd_ptr increments and wraps modulo DEPTH.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Both: unchanged.
  - Push at count 0 with out_ready=1 is not forwarded; the data appears on the next cycle (1-cycle latency from the capture edge to out_valid).
- Overflow: cap while full with no same-cycle pop drops the product and sets overflow=1. overflow clears only on rst.
- Taint:
  - ptr_t is a sticky register, set when (cap & cap_t), or (cap_t & count==DEPTH), or (out_valid & out_ready_t).
  - out_valid_t = ptr_t.
  - full_t = ptr_t.
  - out_data_t = mem_t[rd_ptr] | {2*WIDTH{ptr_t}}.
  - overflow_t is sticky: set when the overflow-set condition is evaluated with cap_t or ptr_t high.
  - All taint registers clear on rst only.
- Reset mid-operation: the FIFO empties in the next cycle and all pending entries are lost. If productDone is still high after reset, a capture occurs on that cycle, because done_q resets to 0.
- Outputs are registered or mux-from-register only; there are no combinational paths from inputs to outputs.

Optional Feature:
- MULT_RESFIFO_OVFCNT_EN
- Defined:
  - Adds output drop_count [7:0] and drop_count_t [0:0].
  - drop_count is a saturating count (stops at 255) of dropped captures.
  - drop_count_t sticky-follows the overflow_t set rule.
  - Both reset to 0.
- Undefined: the ports and counter are absent; the rest of the behaviour is identical.

Test Plan:
- Reset with productDone=1, product=16'h00A5 → first cycle after rst deasserts: out_valid=0, all _t=0. One cycle later: out_valid=1, out_data=16'h00A5.
- Hold productDone high 5 cycles, out_ready=0 → exactly 1 entry captured (out_valid=1, full=0 with DEPTH=4).
- 5 capture pulses (products 1..5), out_ready=0 → full=1 after the 4th; 5th dropped, overflow=1; draining yields 1,2,3,4; drop_count=1 when MULT_RESFIFO_OVFCNT_EN is defined.
- Full FIFO, capture and out_ready=1 in the same cycle → count stays 4, no overflow, new value appears in order after the existing three.
- product=16'h1234, product_t=16'h000F, productDone_t=0 → out_data_t=16'h000F, out_valid_t=0. Repeat with productDone_t=1 → out_data_t=16'hFFFF, out_valid_t=1 and out_valid_t stays 1 until rst.
- Pop with out_ready_t=1 on a clean entry → out_valid_t and full_t become 1 the next cycle; rst returns all taint to 0.
